// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one 8-bit FIFO write port among N valid/ready producers.
// Each grant is a burst of up to MAX_BURST beats and is always followed by one IDLE cycle.
module fifo_wr_arbiter #(
  parameter int N         = 4,
  parameter int MAX_BURST = 4,
  localparam int GW       = $clog2(N),
  localparam int BW       = $clog2(MAX_BURST + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req_valid,
  input  logic [N*8-1:0]  req_data,
  output logic [N-1:0]    req_ready,
  input  logic            fifo_full,
  output logic            fifo_wr_en,
  output logic [7:0]      fifo_data_in,
  output logic [GW-1:0]   grant_id,
  output logic            busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] last_q, last_d;
  logic [BW-1:0] beat_q, beat_d;

  logic          sel_found;
  logic [GW-1:0] sel_idx;
  int            idx;
  logic          xfer;

  // Lowest offset from last_q+1 wins; scanning downwards lets it overwrite later.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    idx       = 0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(last_q) + k) % N;
      if (req_valid[idx]) begin
        sel_found = 1'b1;
        sel_idx   = GW'(idx);
      end
    end
  end

  // Handshake: a beat moves when req_valid[i] & req_ready[i]. req_ready only
  // depends on state, grant and fifo_full, so there is no valid->ready path.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_d       = last_q;
    beat_d       = beat_q;
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_data_in = 8'h00;
    busy         = 1'b0;
    xfer         = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          grant_d = sel_idx;
          beat_d  = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        busy               = 1'b1;
        req_ready[grant_q] = ~fifo_full;
        fifo_data_in       = req_data[{grant_q, 3'b000} +: 8];
        xfer               = req_valid[grant_q] & ~fifo_full;
        fifo_wr_en         = xfer;
        if (xfer) begin
          beat_d = beat_q + BW'(1);
          if (beat_q == BW'(MAX_BURST - 1)) begin
            state_d = IDLE;
            last_d  = grant_q;
          end
        end else if (!fifo_full) begin
          // Producer dropped valid: it gives up the rest of its burst.
          state_d = IDLE;
          last_d  = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GW'(N - 1);
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
    end
  end

  assign grant_id = grant_q;

endmodule
